muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Sequencer for the iterative multiply/divide unit of the multicycle CPU. Accepts a start pulse
//  from the main control unit, drives the unit's init/step strobes, then writes Hi/Lo.
//  Reports completion (done) or a divide-by-zero exception (div0_exc) back to the main FSM.
//  The main FSM holds in a wait state while busy=1.
// PARAMETERS
//  ITER   32  unit_step cycles per operation (>=2)
//  CNT_W  6   iter_cnt width; must satisfy 2**CNT_W > ITER
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-high
//  req            in   1      start request; sampled only in IDLE
//  op             in   1      0 = mult, 1 = div; latched on accept
//  divisor_zero   in   1      B operand == 0; sampled only on accept
//  flush          in   1      synchronous abort from main FSM
//  early_term     in   1      only when MULDIV_EARLY_TERM_EN is defined
//  busy           out  1      high in every state except IDLE
//  unit_init      out  1      load operands into unit (1 cycle)
//  unit_step      out  1      advance unit one iteration
//  unit_sel       out  1      latched op; selects mult or div datapath
//  hilo_write     out  1      Hi/Lo write enable (1 cycle)
//  hilo_src       out  1      Hi/Lo mux select, = latched op (0 mult, 1 div)
//  done           out  1      operation complete (1 cycle)
//  div0_exc       out  1      divide-by-zero exception (1 cycle)
//  iter_cnt       out  CNT_W  steps issued in the current operation
// BEHAVIOUR
//  - Moore FSM. All outputs are decoded from the state register plus the op/cnt registers.
//  - States: IDLE, INIT, RUN, WB, DONE, EXC.
//  - Reset (async): state=IDLE, op_q=0, cnt=0. All outputs are 0 while reset is high and after release.
//  - IDLE: busy=0.
//    - On req & op & divisor_zero: go to EXC.
//    - On req otherwise: go to INIT.
//    - Accepting req latches op into op_q.
//  - INIT: unit_init=1, cnt<=0; go to RUN.
//  - RUN: unit_step=1, cnt<=cnt+1.
//    - Go to WB on the edge where cnt==ITER-1, so exactly ITER step cycles are issued.
//  - WB: hilo_write=1, hilo_src=op_q; go to DONE.
//  - DONE: done=1; go to IDLE.
//  - EXC: div0_exc=1. No init, step or hilo_write is issued. Go to IDLE.
//  - unit_sel=op_q whenever busy; 0 in IDLE.
//  - iter_cnt=cnt. It holds its value through WB and DONE and is cleared on the next INIT or flush.
//  - Latency, counted from the accept edge:
//    - INIT in cycle 1; RUN in cycles 2..ITER+1; WB in cycle ITER+2; done in cycle ITER+3.
//    - EXC in cycle 1.
//  - req while busy is ignored; there is no queueing. op and divisor_zero changes after accept are ignored.
//  - flush in any non-IDLE state: IDLE on the next edge, cnt<=0.
//    - No hilo_write, done or div0_exc follows.
//    - A flush in the same cycle as a state's own pulse still lets that cycle's pulse occur.
//  - flush & req together in IDLE: flush wins; the request is dropped.
//  - Illegal state encodings return to IDLE on the next edge.
// CONFIGURATION
//  MULDIV_EARLY_TERM_EN defined:
//   - The early_term port exists. If early_term=1 in RUN, that cycle's step is the last: go to WB next.
//   - cnt still increments on that cycle.
//   - early_term is ignored in every other state.
//  MULDIV_EARLY_TERM_EN undefined:
//   - The early_term port is absent. RUN always lasts exactly ITER cycles.
// TESTING
//  - mult, ITER=32: req=1,op=0 for 1 cycle. Expect:
//    - unit_init high 1 cycle, then unit_step high 32 consecutive cycles;
//    - hilo_write=1 with hilo_src=0, then done 1 cycle in cycle 35;
//    - iter_cnt=32 at done; busy high for cycles 1..35.
//  - div by zero: req=1,op=1,divisor_zero=1. Expect:
//    - div0_exc=1 in cycle 1 only;
//    - unit_init, unit_step and hilo_write stay 0; busy high for exactly 1 cycle.
//  - div normal: op=1, divisor_zero=0, and req re-pulsed during RUN cycle 5. Expect:
//    - exactly 32 steps; hilo_src=1 and unit_sel=1 throughout;
//    - the second req is ignored: a single done only.
//  - flush at the 10th step cycle: next cycle IDLE, iter_cnt=0, busy=0.
//    - No hilo_write or done follows.
//    - A fresh req then completes normally.
//  - async reset asserted mid-WB (between edges): all outputs drop to 0 immediately.
//    - State is IDLE after release; a new req is accepted on the first edge.
//  - MULDIV_EARLY_TERM_EN: early_term=1 on the 4th step. Expect:
//    - 4 step cycles, hilo_write in the next cycle, done in cycle 7, iter_cnt=4.

Source files
------------

// File: rtl/muldiv_seq.sv
// Control sequencer for the iterative multiply/divide unit: init, ITER steps, Hi/Lo write, done.
// Define MULDIV_EARLY_TERM_EN to add the early_term port, which ends the step phase early.
module muldiv_seq #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             op,
  input  logic             divisor_zero,
  input  logic             flush,
`ifdef MULDIV_EARLY_TERM_EN
  input  logic             early_term,
`endif
  output logic             busy,
  output logic             unit_init,
  output logic             unit_step,
  output logic             unit_sel,
  output logic             hilo_write,
  output logic             hilo_src,
  output logic             done,
  output logic             div0_exc,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4,
    EXC  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t           state;
  state_t           state_nxt;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  // The step phase ends on the cycle whose count is ITER-1, or earlier if the unit finishes early.
  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    last_step = (cnt == LAST_CNT) || early_term;
`else
    last_step = (cnt == LAST_CNT);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req && !flush)
        op_q <= op;
      if (flush || state == INIT)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Flush overrides every transition; DONE, EXC and illegal encodings all fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (req && !flush)
          state_nxt = (op && divisor_zero) ? EXC : INIT;
      end
      INIT:    state_nxt = RUN;
      RUN:     state_nxt = last_step ? WB : RUN;
      WB:      state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_comb begin
    busy       = (state != IDLE);
    unit_sel   = busy & op_q;
    hilo_src   = busy & op_q;
    unit_init  = 1'b0;
    unit_step  = 1'b0;
    hilo_write = 1'b0;
    done       = 1'b0;
    div0_exc   = 1'b0;
    case (state)
      INIT:    unit_init  = 1'b1;
      RUN:     unit_step  = 1'b1;
      WB:      hilo_write = 1'b1;
      DONE:    done       = 1'b1;
      EXC:     div0_exc   = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = cnt;

endmodule
